// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed immediate into the I/S/B/J fields of an RV32I template word,
// tags it with a sequential address and queues it (2 entries). Optional: IMM_ENC_ROUNDTRIP_CHECK_EN.
module imm_encoder #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_immsrc,
  input  logic [31:0]             in_imm,
  input  logic [31:0]             in_base,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic                    out_err,
  output logic [ERRCNT_WIDTH-1:0] err_count
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  ,
  output logic                    chk_fail
`endif
);

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  err;
  } entry_t;

  // Encoder: template bits pass through, immediate fields overwritten.
  logic [31:0] enc_instr;
  logic        enc_err;

  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    case (in_immsrc)
      IMM_I: begin
        enc_instr[31:20] = in_imm[11:0];
        enc_err          = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
      end
      IMM_S: begin
        enc_instr[31:25] = in_imm[11:5];
        enc_instr[11:7]  = in_imm[4:0];
        enc_err          = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
      end
      IMM_B: begin
        enc_instr[31]    = in_imm[12];
        enc_instr[30:25] = in_imm[10:5];
        enc_instr[11:8]  = in_imm[4:1];
        enc_instr[7]     = in_imm[11];
        enc_err          = ~((&in_imm[31:12]) | ~(|in_imm[31:12])) | in_imm[0];
      end
      default: begin
        enc_instr[31]    = in_imm[20];
        enc_instr[30:21] = in_imm[10:1];
        enc_instr[20]    = in_imm[11];
        enc_instr[19:12] = in_imm[19:12];
        enc_err          = ~((&in_imm[31:20]) | ~(|in_imm[31:20])) | in_imm[0];
      end
    endcase
  end

  // Handshake: a transfer occurs on a rising clk edge where valid && ready (and rst is low);
  // valid is never conditioned on ready, and in_ready depends only on registered occupancy.
  entry_t                  slot_q [2];
  entry_t                  slot_d [2];
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              count_q, count_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;
  logic                    push, pop;
  entry_t                  head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = slot_q[rd_ptr_q];
  assign out_instr = head.instr;
  assign out_addr  = head.addr;
  assign out_err   = head.err;
  assign err_count = errcnt_q;

  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    errcnt_d  = errcnt_q;
    if (push) begin
      slot_d[wr_ptr_q] = '{instr: enc_instr, addr: addr_q, err: enc_err};
      wr_ptr_d         = ~wr_ptr_q;
      addr_d           = addr_q + ADDR_WIDTH'(4);
      if (enc_err && (errcnt_q != '1)) begin
        errcnt_d = errcnt_q + ERRCNT_WIDTH'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      addr_q    <= BASE_ADDR;
      errcnt_q  <= '0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      errcnt_q  <= errcnt_d;
    end
  end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  // Decode the freshly encoded word with the core's sign-extend rules.
  logic [31:0] dec_imm;
  logic        chk_fail_q, chk_fail_d;

  always_comb begin
    dec_imm = '0;
    case (in_immsrc)
      IMM_I:   dec_imm = {{20{enc_instr[31]}}, enc_instr[31:20]};
      IMM_S:   dec_imm = {{20{enc_instr[31]}}, enc_instr[31:25], enc_instr[11:7]};
      IMM_B:   dec_imm = {{19{enc_instr[31]}}, enc_instr[31], enc_instr[7],
                          enc_instr[30:25], enc_instr[11:8], 1'b0};
      default: dec_imm = {{11{enc_instr[31]}}, enc_instr[31], enc_instr[19:12],
                          enc_instr[20], enc_instr[30:21], 1'b0};
    endcase
    chk_fail_d = chk_fail_q | (push && !enc_err && (dec_imm != in_imm));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_fail_q <= 1'b0;
    end else begin
      chk_fail_q <= chk_fail_d;
    end
  end

  assign chk_fail = chk_fail_q;
`endif

endmodule
